// File: rtl/updown_pulse_conditioner.sv
// -----------------------------------------------------------------------------
// updown_pulse_conditioner
//
// Front end for the up/down event counter. The raw up and down request lines
// are asynchronous. This block synchronises each one into the clk domain and
// glitch-filters it. Every qualified rising edge is counted as one pending
// event. A small arbiter then drains the pending events as clean single-cycle
// pulses. The pulses never overlap, and each one is followed by at least two
// idle cycles.
//
// Ports
//   clk           system clock, all state on the rising edge
//   reset         asynchronous, active-high; clears every register at once
//   up_raw        raw up request (asynchronous)
//   down_raw      raw down request (asynchronous)
//   up_pulse      one-cycle up event towards the counter
//   down_pulse    one-cycle down event towards the counter
//   up_pending    accepted up events not yet emitted
//   down_pending  accepted down events not yet emitted
//   overflow      sticky: an accepted event was dropped on a full counter
//   busy          events pending or arbiter not idle
// -----------------------------------------------------------------------------
module updown_pulse_conditioner #(
    parameter int SYNC_STAGES   = 2,
    parameter int FILTER_CYCLES = 4,
    parameter int PEND_WIDTH    = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  up_raw,
    input  logic                  down_raw,
    output logic                  up_pulse,
    output logic                  down_pulse,
    output logic [PEND_WIDTH-1:0] up_pending,
    output logic [PEND_WIDTH-1:0] down_pending,
    output logic                  overflow,
    output logic                  busy
);

    localparam int               CNT_W      = $clog2(FILTER_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_TARGET = CNT_W'(FILTER_CYCLES);
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

    typedef enum logic [1:0] {
        F_LOW,
        F_QUAL_HIGH,
        F_HIGH,
        F_QUAL_LOW
    } filt_state_t;

    typedef enum logic [1:0] {
        A_IDLE,
        A_EMIT,
        A_GAP
    } arb_state_t;

    // Direction index: 0 = up, 1 = down.
    logic [1:0]            raw;
    logic [1:0]            emit;
    logic [1:0]            lost;
    logic [1:0]            nonzero;
    logic [PEND_WIDTH-1:0] pend [2];

    assign raw  = {down_raw, up_raw};
    // A registered pulse is exactly the cycle in which its event leaves the queue.
    assign emit = {down_pulse, up_pulse};

    for (genvar d = 0; d < 2; d++) begin : g_dir
        logic [SYNC_STAGES-1:0] sync_q;
        logic                   sync;
        filt_state_t            state_q, state_d;
        logic [CNT_W-1:0]       cnt_q, cnt_d, cnt_inc;
        logic                   accept_d, accept_q;
        logic [PEND_WIDTH-1:0]  pend_q;

        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                sync_q <= '0;
            end else begin
                sync_q <= {sync_q[SYNC_STAGES-2:0], raw[d]};
            end
        end

        assign sync    = sync_q[SYNC_STAGES-1];
        assign cnt_inc = cnt_q + CNT_ONE;

        // NOTE: every always_comb output is given a default first, so no latch can be inferred.
        always_comb begin
            state_d  = state_q;
            cnt_d    = cnt_q;
            accept_d = 1'b0;
            unique case (state_q)
                F_LOW: begin
                    if (sync) begin
                        if (FILTER_CYCLES == 1) begin
                            state_d  = F_HIGH;
                            accept_d = 1'b1;
                        end else begin
                            state_d = F_QUAL_HIGH;
                            cnt_d   = CNT_ONE;
                        end
                    end
                end
                F_QUAL_HIGH: begin
                    if (!sync) begin
                        state_d = F_LOW;
                    end else if (cnt_inc == CNT_TARGET) begin
                        state_d  = F_HIGH;
                        accept_d = 1'b1;
                    end else begin
                        cnt_d = cnt_inc;
                    end
                end
                F_HIGH: begin
                    if (!sync) begin
                        if (FILTER_CYCLES == 1) begin
                            state_d = F_LOW;
                        end else begin
                            state_d = F_QUAL_LOW;
                            cnt_d   = CNT_ONE;
                        end
                    end
                end
                F_QUAL_LOW: begin
                    // A short dropout returns to HIGH without a new accept.
                    if (sync) begin
                        state_d = F_HIGH;
                    end else if (cnt_inc == CNT_TARGET) begin
                        state_d = F_LOW;
                    end else begin
                        cnt_d = cnt_inc;
                    end
                end
                default: state_d = F_LOW;
            endcase
        end

        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                state_q  <= F_LOW;
                cnt_q    <= '0;
                accept_q <= 1'b0;
            end else begin
                state_q  <= state_d;
                cnt_q    <= cnt_d;
                accept_q <= accept_d;
            end
        end

        // If an accept and an emit land in the same cycle, they cancel out.
        // An accept that arrives on a full counter is dropped.
        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                pend_q <= '0;
            end else if (accept_q && !emit[d]) begin
                if (pend_q != '1) begin
                    pend_q <= pend_q + PEND_WIDTH'(1);
                end
            end else if (!accept_q && emit[d]) begin
                pend_q <= pend_q - PEND_WIDTH'(1);
            end
        end

        assign lost[d]    = accept_q && !emit[d] && (pend_q == '1);
        assign pend[d]    = pend_q;
        assign nonzero[d] = (pend_q != '0);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            overflow <= 1'b0;
        end else if (|lost) begin
            overflow <= 1'b1;
        end
    end

    // Output arbiter: IDLE -> EMIT -> GAP -> IDLE. With this sequence the
    // outputs carry at most one pulse every three cycles.
    arb_state_t arb_q, arb_d;
    logic       token_q, token_d;   // 0 = up has priority, 1 = down
    logic       grant_down;
    logic       up_pulse_d, down_pulse_d;

    always_comb begin
        arb_d        = arb_q;
        token_d      = token_q;
        grant_down   = 1'b0;
        up_pulse_d   = 1'b0;
        down_pulse_d = 1'b0;
        unique case (arb_q)
            A_IDLE: begin
                if (|nonzero) begin
                    grant_down   = (nonzero == 2'b11) ? token_q : nonzero[1];
                    up_pulse_d   = !grant_down;
                    down_pulse_d = grant_down;
                    token_d      = !token_q;
                    arb_d        = A_EMIT;
                end
            end
            A_EMIT:  arb_d = A_GAP;
            A_GAP:   arb_d = A_IDLE;
            default: arb_d = A_IDLE;
        endcase
    end

    // The pulse registers load on the same edge that enters EMIT. The pulse is
    // therefore high for exactly the EMIT cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            arb_q      <= A_IDLE;
            token_q    <= 1'b0;
            up_pulse   <= 1'b0;
            down_pulse <= 1'b0;
        end else begin
            arb_q      <= arb_d;
            token_q    <= token_d;
            up_pulse   <= up_pulse_d;
            down_pulse <= down_pulse_d;
        end
    end

    assign up_pending   = pend[0];
    assign down_pending = pend[1];
    assign busy         = (|nonzero) || (arb_q != A_IDLE);

endmodule

// File: tb/tb_updown_pulse_conditioner.sv
// -----------------------------------------------------------------------------
// Testbench for updown_pulse_conditioner.
// u_dut  : default parameters; scoreboard of expected pulses (direction, cycle).
// u_dut2 : FILTER_CYCLES=1 so the queues can be overrun; a pending-counter
//          model tracks saturation, drops and the sticky overflow flag.
// -----------------------------------------------------------------------------
module tb_updown_pulse_conditioner;

    localparam int SYNC  = 2;
    localparam int FILT  = 4;
    localparam int PW    = 4;
    localparam int FILT2 = 1;
    // The input goes high at a negedge while cyc == c. The pulse is then seen
    // by the monitor (posedge + 1) with cyc == c + SYNC + FILT + 2.
    localparam int LAT   = SYNC + FILT + 2;
    // dut2: the pending count reflects an accept when cyc == c + SYNC + FILT2 + 1.
    localparam int INC2  = SYNC + FILT2 + 1;
    localparam int N_OVF = 40;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst, up_raw, down_raw;
    logic          up_pulse, down_pulse, overflow, busy;
    logic [PW-1:0] up_pending, down_pending;

    logic          rst2, up_raw2, down_raw2;
    logic          up_pulse2, down_pulse2, overflow2, busy2;
    logic [PW-1:0] up_pending2, down_pending2;

    updown_pulse_conditioner #(.SYNC_STAGES(SYNC), .FILTER_CYCLES(FILT), .PEND_WIDTH(PW)) u_dut (
        .clk(clk), .reset(rst), .up_raw(up_raw), .down_raw(down_raw),
        .up_pulse(up_pulse), .down_pulse(down_pulse),
        .up_pending(up_pending), .down_pending(down_pending),
        .overflow(overflow), .busy(busy)
    );

    updown_pulse_conditioner #(.SYNC_STAGES(SYNC), .FILTER_CYCLES(FILT2), .PEND_WIDTH(PW)) u_dut2 (
        .clk(clk), .reset(rst2), .up_raw(up_raw2), .down_raw(down_raw2),
        .up_pulse(up_pulse2), .down_pulse(down_pulse2),
        .up_pending(up_pending2), .down_pending(down_pending2),
        .overflow(overflow2), .busy(busy2)
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_tests++;
        if (actual !== expected) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (cyc %0d)", name, actual, expected, cyc);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    // ---------------- scoreboard for u_dut ----------------
    typedef struct {
        logic is_down;
        int   stamp;
    } exp_t;
    exp_t exp_q[$];
    int   last_pulse = -100;

    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (up_pulse || down_pulse) begin
                check("no_overlap", {31'b0, up_pulse & down_pulse}, 0);
                check("spacing_ge3", {31'b0, (cyc - last_pulse) >= 3}, 1);
                last_pulse = cyc;
                if (exp_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_pulse: up=%0b down=%0b at cyc %0d, none expected", up_pulse, down_pulse, cyc);
                end else begin
                    e = exp_q.pop_front();
                    check("pulse_dir_down", {31'b0, down_pulse}, {31'b0, e.is_down});
                    check("pulse_cycle", cyc, e.stamp);
                end
            end
        end
    end

    // ---------------- pending model for u_dut2 ----------------
    bit   m2_on = 0;
    int   inc_up[$];
    int   inc_dn[$];
    int   m_up = 0, m_dn = 0, drop_up = 0, drop_dn = 0;
    int   emit_up2 = 0, emit_dn2 = 0, peak_up2 = 0, last2 = -100;
    logic prev_up2 = 1'b0, prev_dn2 = 1'b0;

    task automatic step_model(input bit inc, input bit em, inout int m, inout int drop);
        if (inc && !em) begin
            if (m == (1 << PW) - 1) drop++;
            else m++;
        end else if (!inc && em) begin
            m--;
        end
    endtask

    initial begin
        bit inc_u, inc_d;
        forever begin
            @(posedge clk);
            #1;
            if (m2_on) begin
                inc_u = 0;
                inc_d = 0;
                if (inc_up.size() != 0 && inc_up[0] == cyc) begin
                    inc_u = 1;
                    void'(inc_up.pop_front());
                end
                if (inc_dn.size() != 0 && inc_dn[0] == cyc) begin
                    inc_d = 1;
                    void'(inc_dn.pop_front());
                end
                step_model(inc_u, prev_up2, m_up, drop_up);
                step_model(inc_d, prev_dn2, m_dn, drop_dn);
                check("dut2_up_pending", {28'b0, up_pending2}, m_up);
                check("dut2_down_pending", {28'b0, down_pending2}, m_dn);
                check("dut2_overflow", {31'b0, overflow2}, {31'b0, (drop_up + drop_dn) > 0});
                if (int'(up_pending2) > peak_up2) peak_up2 = int'(up_pending2);
                if (up_pulse2 || down_pulse2) begin
                    check("dut2_no_overlap", {31'b0, up_pulse2 & down_pulse2}, 0);
                    check("dut2_spacing_ge3", {31'b0, (cyc - last2) >= 3}, 1);
                    last2 = cyc;
                    emit_up2 += int'(up_pulse2);
                    emit_dn2 += int'(down_pulse2);
                end
            end
            prev_up2 = up_pulse2;
            prev_dn2 = down_pulse2;
        end
    end

    task automatic check_clear(input string tag, input logic up_p, input logic dn_p,
                               input logic [PW-1:0] up_c, input logic [PW-1:0] dn_c,
                               input logic ovf, input logic bsy);
        check({tag, "_up_pulse"}, {31'b0, up_p}, 0);
        check({tag, "_down_pulse"}, {31'b0, dn_p}, 0);
        check({tag, "_up_pending"}, {28'b0, up_c}, 0);
        check({tag, "_down_pending"}, {28'b0, dn_c}, 0);
        check({tag, "_overflow"}, {31'b0, ovf}, 0);
        check({tag, "_busy"}, {31'b0, bsy}, 0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick(2);
        rst = 1'b0;
        tick(2);
    endtask

    // watchdog
    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, cyc %0d", cyc);
        $fatal(1, "timeout");
    end

    initial begin
        int  c0;
        bit  found;
        rst = 1'b1; up_raw = 1'b0; down_raw = 1'b0;
        rst2 = 1'b1; up_raw2 = 1'b0; down_raw2 = 1'b0;
        tick(3);
        check_clear("reset", up_pulse, down_pulse, up_pending, down_pending, overflow, busy);
        check_clear("reset2", up_pulse2, down_pulse2, up_pending2, down_pending2, overflow2, busy2);
        rst = 1'b0;
        tick(2);

        // ---- clean up for 20 cycles: one pulse at LAT, pending 1 -> 0, busy drop
        c0 = cyc;
        up_raw = 1'b1;
        exp_q.push_back('{1'b0, c0 + LAT});
        tick(6);
        check("t1_pending_before_accept", {28'b0, up_pending}, 0);
        tick(1);
        check("t1_pending_after_accept", {28'b0, up_pending}, 1);
        check("t1_busy_rises", {31'b0, busy}, 1);
        tick(2);
        check("t1_pending_after_emit", {28'b0, up_pending}, 0);
        check("t1_busy_in_gap", {31'b0, busy}, 1);
        tick(1);
        check("t1_busy_after_gap", {31'b0, busy}, 0);
        tick(10);
        up_raw = 1'b0;
        tick(15);

        // ---- 3-cycle glitch: rejected
        do_reset();
        up_raw = 1'b1;
        tick(3);
        up_raw = 1'b0;
        tick(3);
        check("t2_glitch_pending", {28'b0, up_pending}, 0);
        tick(17);
        check("t2_glitch_busy", {31'b0, busy}, 0);

        // ---- high with a 2-cycle dropout: single pulse
        c0 = cyc;
        up_raw = 1'b1;
        exp_q.push_back('{1'b0, c0 + LAT});
        tick(5);
        up_raw = 1'b0;
        tick(2);
        up_raw = 1'b1;
        tick(5);
        up_raw = 1'b0;
        tick(25);
        check("t2_dropout_pending", {28'b0, up_pending}, 0);
        check("t2_dropout_busy", {31'b0, busy}, 0);

        // ---- simultaneous up and down: up first, down 3 cycles later
        do_reset();
        c0 = cyc;
        up_raw = 1'b1;
        down_raw = 1'b1;
        exp_q.push_back('{1'b0, c0 + LAT});
        exp_q.push_back('{1'b1, c0 + LAT + 3});
        tick(20);
        up_raw = 1'b0;
        down_raw = 1'b0;
        tick(25);
        check("t3_down_pending", {28'b0, down_pending}, 0);
        check("t3_busy", {31'b0, busy}, 0);

        // ---- reset in EMIT with input held high: new pulse LAT after release
        do_reset();
        c0 = cyc;
        up_raw = 1'b1;
        exp_q.push_back('{1'b0, c0 + LAT});
        tick(LAT);
        check("t4_pulse_before_reset", {31'b0, up_pulse}, 1);
        check("t4_pending_in_emit", {28'b0, up_pending}, 1);
        rst = 1'b1;
        #1;
        check_clear("t4_async_reset", up_pulse, down_pulse, up_pending, down_pending, overflow, busy);
        tick(3);
        rst = 1'b0;
        c0 = cyc;
        exp_q.push_back('{1'b0, c0 + LAT});
        tick(20);
        up_raw = 1'b0;
        tick(20);

        // ---- dut2: reach EMIT with up_pending = 3, then reset
        rst2 = 1'b0;
        tick(2);
        found = 0;
        for (int i = 0; i < 40 && !found; i++) begin
            up_raw2 = 1'b1;
            down_raw2 = 1'b1;
            tick(1);
            if (up_pulse2 && up_pending2 == PW'(3)) begin
                found = 1;
            end else begin
                up_raw2 = 1'b0;
                down_raw2 = 1'b0;
                tick(1);
                if (up_pulse2 && up_pending2 == PW'(3)) found = 1;
            end
        end
        check("t5_reached_emit_pending3", {31'b0, found}, 1);
        rst2 = 1'b1;
        #1;
        check_clear("t5_async_reset", up_pulse2, down_pulse2, up_pending2, down_pending2, overflow2, busy2);
        up_raw2 = 1'b0;
        down_raw2 = 1'b0;
        tick(3);
        rst2 = 1'b0;
        tick(2);

        // ---- dut2: overrun both queues
        m2_on = 1;
        for (int i = 0; i < N_OVF; i++) begin
            c0 = cyc;
            up_raw2 = 1'b1;
            down_raw2 = 1'b1;
            inc_up.push_back(c0 + INC2);
            inc_dn.push_back(c0 + INC2);
            tick(1);
            up_raw2 = 1'b0;
            down_raw2 = 1'b0;
            tick(1);
        end
        tick(150);
        check("t6_up_peak_saturates", peak_up2, 15);
        check("t6_up_dropped_some", {31'b0, drop_up > 0}, 1);
        check("t6_overflow_sticky", {31'b0, overflow2}, 1);
        check("t6_up_emitted", emit_up2, N_OVF - drop_up);
        check("t6_down_emitted", emit_dn2, N_OVF - drop_dn);
        check("t6_drained_up", {28'b0, up_pending2}, 0);
        check("t6_drained_busy", {31'b0, busy2}, 0);

        check("scoreboard_empty", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
